// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared constants and types for the register-file writeback
//               arbiter: data width, register count, address width, the
//               writeback source encoding and the hardwired-zero address.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  localparam logic [AW-1:0] X0_ADDR = '0;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Bundle of every non-clock/reset signal of the writeback
//               arbiter. master = requesters/decode side, slave = arbiter.
//   alu_valid/alu_rd/alu_data -> alu_ready   ALU writeback handshake
//   mem_valid/mem_rd/mem_data -> mem_ready   load writeback handshake
//   rsv_valid/rsv_rd          -> rsv_ready   destination reservation
//   a1/a2/use_a1/use_a2       -> stall       RAW hazard query
//   we_rf/a3/wd                              registered regfile write port
//   busy                                     pending-write scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_rd;
  logic            rsv_ready;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic            use_a1;
  logic            use_a2;
  logic            stall;
  logic            we_rf;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd;
  logic [NREG-1:0] busy;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           rsv_valid, rsv_rd, a1, a2, use_a1, use_a2,
    input  alu_ready, mem_ready, rsv_ready, stall, we_rf, a3, wd, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           rsv_valid, rsv_rd, a1, a2, use_a1, use_a2,
    output alu_ready, mem_ready, rsv_ready, stall, we_rf, a3, wd, busy
  );

endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_rr_arb2
// Description : Two-way round-robin arbiter (ALU vs MEM). A lone request is
//               granted; on a tie the source not granted last wins.
//   clk, rst                 clock, asynchronous active-high reset
//   valid_alu_i/valid_mem_i  request inputs
//   grant_alu_o/grant_mem_o  combinational one-hot (or zero) grants
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter_rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid_alu_i,
  input  logic valid_mem_i,
  output logic grant_alu_o,
  output logic grant_mem_o
);

  src_e last_grant_q;
  src_e last_grant_d;

  always_comb begin
    grant_alu_o  = 1'b0;
    grant_mem_o  = 1'b0;
    last_grant_d = last_grant_q;
    if (valid_alu_i && valid_mem_i) begin
      if (last_grant_q == SRC_MEM) grant_alu_o = 1'b1;
      else                         grant_mem_o = 1'b1;
    end else begin
      grant_alu_o = valid_alu_i;
      grant_mem_o = valid_mem_i;
    end
    // Every grant is an accepted handshake, so history follows the grant.
    if (grant_alu_o)      last_grant_d = SRC_ALU;
    else if (grant_mem_o) last_grant_d = SRC_MEM;
  end

  // Reset to MEM so the first tie after reset favours the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= SRC_MEM;
    else     last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Serialises ALU and load writebacks onto the single register
//               file write port and tracks pending writes per register to
//               flag RAW hazards on the decode operands.
//   clk, rst  clock, asynchronous active-high reset
//   wb        rf_wb_arbiter_if.slave (handshakes, scoreboard, write port)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave wb
);

  logic            w_alu_gnt;
  logic            w_mem_gnt;
  logic            w_accept;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic            w_rsv_ready;

  logic            we_rf_q, we_rf_d;
  logic [AW-1:0]   a3_q,    a3_d;
  logic [XLEN-1:0] wd_q,    wd_d;
  logic [NREG-1:0] busy_q,  busy_d;

  rf_wb_arbiter_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid_alu_i (wb.alu_valid),
    .valid_mem_i (wb.mem_valid),
    .grant_alu_o (w_alu_gnt),
    .grant_mem_o (w_mem_gnt)
  );

  always_comb begin
    w_accept = w_alu_gnt | w_mem_gnt;
    w_rd     = w_mem_gnt ? wb.mem_rd   : wb.alu_rd;
    w_data   = w_mem_gnt ? wb.mem_data : wb.alu_data;

    // x0 writes are accepted but never reach the register file.
    we_rf_d = w_accept && (w_rd != X0_ADDR);
    a3_d    = a3_q;
    wd_d    = wd_q;
    if (we_rf_d) begin
      a3_d = w_rd;
      wd_d = w_data;
    end

    // Reservation looks only at the registered scoreboard, never at a
    // clear happening this same edge: this keeps WAW ordering simple.
    w_rsv_ready = (wb.rsv_rd == X0_ADDR) || !busy_q[wb.rsv_rd];

    // Clear first, then set, so a same-edge set of the same register wins.
    busy_d = busy_q;
    if (we_rf_q) busy_d[a3_q] = 1'b0;
    if (wb.rsv_valid && w_rsv_ready && (wb.rsv_rd != X0_ADDR))
      busy_d[wb.rsv_rd] = 1'b1;
    busy_d[X0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_rf_q <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
      busy_q  <= '0;
    end else begin
      we_rf_q <= we_rf_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign wb.alu_ready = w_alu_gnt;
  assign wb.mem_ready = w_mem_gnt;
  assign wb.rsv_ready = w_rsv_ready;
  // No bypass: an operand stays stalled through the cycle its write lands.
  assign wb.stall = (wb.use_a1 && (wb.a1 != X0_ADDR) && busy_q[wb.a1]) ||
                    (wb.use_a2 && (wb.a2 != X0_ADDR) && busy_q[wb.a2]);
  assign wb.we_rf = we_rf_q;
  assign wb.a3    = a3_q;
  assign wb.wd    = wd_q;
  assign wb.busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Sequences all writes into the single-write-port register file of the multicycle core. Two writeback sources, ALU result and memory load data, request through valid/ready handshakes. The block arbitrates them round-robin and drives the register file write port (we_rf/a3/wd) from registers. It also keeps a per-register pending-write scoreboard and raises a stall when a source operand on a1/a2 still has a write outstanding.

Parameters:
XLEN, 32, data width of the register file
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width, equal to log2(NREG)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
alu_valid  in  1  ALU writeback request
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_rd  in  AW  load destination register
mem_data  in  XLEN  load data
mem_ready  out  1  load request accepted this cycle
rsv_valid  in  1  decode reserves destination rsv_rd
rsv_rd  in  AW  register to mark pending
rsv_ready  out  1  reservation accepted
a1  in  AW  source register 1 under decode
a2  in  AW  source register 2 under decode
use_a1  in  1  a1 is a real operand
use_a2  in  1  a2 is a real operand
stall  out  1  RAW hazard on a1/a2
we_rf  out  1  register file write enable (registered)
a3  out  AW  register file write address (registered)
wd  out  XLEN  register file write data (registered)
busy  out  NREG  scoreboard bitmap, bit i means write to xi pending

Behaviour:
- Reset (async, immediate): we_rf=0, a3=0, wd=0, busy=0, last_grant=MEM, so the first tie goes to ALU.
- Arbitration is combinational in the current cycle. If only one source is valid, it is granted. If both are valid, the source not in last_grant wins. last_grant updates on every accepted handshake.
- alu_ready/mem_ready = grant. At most one is high per cycle, and a ready never goes high without its valid.
- Requester rule: valid, rd and data stay stable until ready. Valid must not drop before acceptance. A source requester violation is undefined behaviour and must be flagged by a bench assertion.
- Handshake at edge N: at N+1, we_rf=1, a3=rd, wd=data. We_rf lasts exactly one cycle unless another handshake occurs. Back-to-back grants give continuous we_rf.
- rd==0: the request is still accepted (ready=1) and last_grant still updates, but we_rf stays 0 next cycle.
- Scoreboard set: rsv_valid && rsv_ready && rsv_rd!=0 sets busy[rsv_rd] at the edge.
- rsv_ready = (rsv_rd==0) or !busy[rsv_rd]. This blocks WAW on pending registers. rsv_ready depends only on busy, not on same-cycle clears.
- Scoreboard clear: at the edge where we_rf=1 (the regfile captures at that same edge), busy[a3] clears. After that edge the register holds the new value and busy is 0.
- If a set and a clear of the same register happen at the same edge, set wins. This is only reachable when busy was 0, which means a write to an unreserved register.
- Writes to unreserved registers are permitted. The clear of an already-0 bit is a no-op.
- stall = (use_a1 && a1!=0 && busy[a1]) || (use_a2 && a2!=0 && busy[a2]). It is combinational from busy, with no bypass.
- busy[0] is never set.
- Reset asserted mid-operation discards any pending we_rf and all busy bits. Requesters re-present requests after reset.

Decomposition:
- Shared package holds XLEN, NREG, AW, the source enum (SRC_ALU=0, SRC_MEM=1), and the x0 address constant.
- One natural sub-module, rr_arb2: a 2-way round-robin arbiter with valid inputs, grant outputs and a last_grant register. The scoreboard stays inline.

Test Plan:
- Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle we_rf=1, a3=5, wd=0xDEADBEEF; following cycle we_rf=0.
- alu_valid and mem_valid held with rd=3/rd=4 from reset -> grants ALU, MEM, ALU, MEM on consecutive cycles; we_rf continuously 1 with a3 alternating 3,4,3,4.
- rsv x7, then a1=7, use_a1=1 -> stall=1; mem write x7 accepted -> stall stays 1 through the we_rf cycle and drops the cycle after the we_rf edge; busy[7]=0.
- rsv_rd=7 while busy[7]=1 -> rsv_ready=0 and busy unchanged; rsv_rd=0 -> rsv_ready=1 and busy[0] stays 0.
- alu_rd=0, data=0x1234 -> alu_ready=1, we_rf stays 0, last_grant=ALU (next tie goes to MEM).
- Handshake at edge N, then reset asserted mid-cycle before N+1 -> we_rf=0 and busy=0 immediately, with no clock needed.
